// File: rtl/x_shifter_pkg.sv
// Shared constants and helpers for the x_shifter barrel-shifter datapath.
package x_shifter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/x_shifter_shift_stage.sv
// One mux stage of the logarithmic shifter: passes or left-shifts by DIST.
module shift_stage
    import x_shifter_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic [DATA_W-1:0] in,
    input  logic              en,
    output logic [DATA_W-1:0] out
);

    assign out = en ? (in << DIST) : in;

endmodule

// File: rtl/x_shifter.sv
// 32-bit logical barrel shifter with a registered result; right shifts reuse
// the left-shift chain by bit-reversing around it.
module x_shifter
    import x_shifter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] amt,
    input  logic               direc,
    output logic [DATA_W-1:0]  result
);

    logic [SHAMT_W:0][DATA_W-1:0] chain;
    logic [DATA_W-1:0]            result_d;
    logic [DATA_W-1:0]            result_q;

    assign chain[0] = (direc == DIR_RIGHT) ? bit_rev(data) : data;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .DIST(1 << k)
        ) u_stage (
            .in  (chain[k]),
            .en  (amt[k]),
            .out (chain[k+1])
        );
    end

    always_comb begin
        result_d = chain[SHAMT_W];
        if (direc == DIR_RIGHT) begin
            result_d = bit_rev(chain[SHAMT_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_x_shifter.sv
// Self-checking bench for x_shifter: directed cases, pipelined back-to-back
// operations and a randomized sweep over every amount and direction.
module tb_x_shifter;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic [4:0]  amt;
    logic        direc;
    logic [31:0] result;

    int total;
    int bad;

    x_shifter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (data),
        .amt    (amt),
        .direc  (direc),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a,
                                              input logic dir, input logic rn);
        if (!rn) return 32'h0;
        return dir ? (d >> a) : (d << a);
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        total++;
        assert (result === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, result, exp);
        end
    endtask

    // Apply one operation at the falling edge, then check it one rising edge later.
    task automatic step(input string tag, input logic [31:0] d, input logic [4:0] a,
                        input logic dir, input logic rn);
        logic [31:0] exp;
        @(negedge clk);
        data  = d;
        amt   = a;
        direc = dir;
        rst_n = rn;
        exp   = ref_shift(d, int'(a), dir, rn);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [31:0] pd [4];
        logic [4:0]  pa [4];
        logic        pr [4];
        logic [31:0] rd;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        data  = 32'hFFFF_FFFF;
        amt   = 5'd3;
        direc = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step("reset_hold", 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b0);
        end

        step("first_after_reset", 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b1);
        check("first_after_reset_const", 32'hFFFF_FFF8);

        step("left_basic", 32'h0000_0002, 5'd10, 1'b0, 1'b1);
        check("left_basic_const", 32'h0000_0800);
        step("right_basic", 32'h0000_002F, 5'd5, 1'b1, 1'b1);
        check("right_basic_const", 32'h0000_0001);

        step("amt0_left", 32'h8000_0001, 5'd0, 1'b0, 1'b1);
        check("amt0_left_const", 32'h8000_0001);
        step("amt0_right", 32'h8000_0001, 5'd0, 1'b1, 1'b1);
        check("amt0_right_const", 32'h8000_0001);
        step("amt31_left", 32'h8000_0001, 5'd31, 1'b0, 1'b1);
        check("amt31_left_const", 32'h8000_0000);
        step("amt31_right", 32'h8000_0001, 5'd31, 1'b1, 1'b1);
        check("amt31_right_const", 32'h0000_0001);
        step("zero_fill", 32'hFFFF_FFFF, 5'd16, 1'b1, 1'b1);
        check("zero_fill_const", 32'h0000_FFFF);

        pd[0] = 32'h1234_5678; pa[0] = 5'd4;  pr[0] = 1'b0;
        pd[1] = 32'hDEAD_BEEF; pa[1] = 5'd8;  pr[1] = 1'b1;
        pd[2] = 32'hA5A5_0F0F; pa[2] = 5'd1;  pr[2] = 1'b1;
        pd[3] = 32'h0000_FFFF; pa[3] = 5'd17; pr[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("pipeline", pd[i], pa[i], pr[i], 1'b1);
        end

        for (int dir = 0; dir < 2; dir++) begin
            for (int a = 0; a < 32; a++) begin
                rd = $urandom;
                if (dir == 1 && a == 12) begin
                    step("sweep_reset", rd, 5'(a), 1'(dir), 1'b0);
                end
                step("sweep", rd, 5'(a), 1'(dir), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
